// File: rtl/perceptron_sequencer.sv
// rtl/perceptron_sequencer.sv - sequences one perceptron dot product, then adds bias, applies ReLU and saturates
// Drives memory reads, aligns the accumulate enable and presents the (3,5) activation on valid/ready.
module perceptron_sequencer #(
  parameter int NUM_INPUTS = 784,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  acc_clr,
  output logic                  acc_en,
  input  logic signed [12:0]    acc_sum,
  input  logic signed [7:0]     bias,
  output logic signed [7:0]     act_out,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_DRAIN1, S_DRAIN2, S_ACT, S_OUT
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_INPUTS - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  acc_en_q, acc_en_d;
  logic [7:0]            act_q, act_d;
  logic signed [13:0]    y;

  // 14 bits hold any (8,5) sum plus (3,5) bias without overflow
  assign y = $signed({acc_sum[12], acc_sum}) + $signed({{6{bias[7]}}, bias});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      acc_en_q <= 1'b0;
      act_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      acc_en_q <= acc_en_d;
      act_q    <= act_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    act_d    = act_q;
    acc_en_d = (state_q == S_FETCH);
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        addr_d  = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_DRAIN1;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN1: state_d = S_DRAIN2;
      S_DRAIN2: state_d = S_ACT;
      S_ACT: begin
        if (y[13])          act_d = 8'h00;
        else if (|y[12:7])  act_d = 8'h7F;
        else                act_d = {1'b0, y[6:0]};
        state_d = S_OUT;
      end
      S_OUT:    if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign rd_en     = (state_q == S_FETCH);
  assign acc_clr   = (state_q == S_CLEAR);
  assign out_valid = (state_q == S_OUT);
  assign acc_en    = acc_en_q;
  assign rd_addr   = addr_q;
  assign act_out   = act_q;

endmodule
